et_len_ctrl: RTL and testbench

Early-termination stream-length controller for the SC datapath. It accepts a bundle of C binary operands and finds the precision each one actually needs from its trailing-zero count. It then runs an SC cycle counter for 2^P cycles, where P is the largest needed precision across channels. It sits between the operand source and the SNG/comparator array, whose RNG index it drives through `cnt`.

---
 rtl/et_len_ctrl.sv | 112 +++++++++++
 tb/tb_et_len_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/et_len_ctrl.sv
// rtl/et_len_ctrl.sv - early-termination stream-length controller for the SC datapath
module et_len_ctrl #(
  parameter int W  = 6,
  parameter int C  = 2,
  parameter int PW = $clog2(W+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            et_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [C*W-1:0]  Bx,
  input  logic            abort,
  output logic            run,
  output logic [W-1:0]    cnt,
  output logic            last,
  output logic [PW-1:0]   prec,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

  state_t          state;
  logic [C*W-1:0]  bx_r;
  logic            et_r;
  logic [PW-1:0]   p_ch [C];
  logic [PW-1:0]   p_calc;
  logic [W:0]      lm1_calc;
  logic [W:0]      lm1_run;
  logic [W:0]      cnt_inc;

  // Scanning MSB to LSB leaves the lowest set bit's precision, i.e. W - tz.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      p_ch[i] = '0;
      for (int b = W-1; b >= 0; b--) begin
        if (bx_r[i*W+b]) p_ch[i] = PW'(W-b);
      end
    end
  end

  always_comb begin
    p_calc = et_r ? '0 : PW'(W);
    if (et_r) begin
      for (int i = 0; i < C; i++) begin
        if (p_ch[i] > p_calc) p_calc = p_ch[i];
      end
    end
  end

  // L-1 in W+1 bits so that P=W yields all ones in the low W bits.
  assign lm1_calc = ((W+1)'(1) << p_calc) - (W+1)'(1);
  assign lm1_run  = ((W+1)'(1) << prec)   - (W+1)'(1);
  assign cnt_inc  = {1'b0, cnt} + (W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      run      <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      prec     <= '0;
      bx_r     <= '0;
      et_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            bx_r     <= Bx;
            et_r     <= et_en;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          prec <= p_calc;
          cnt  <= '0;
          if (abort) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            run   <= 1'b1;
            last  <= (lm1_calc == '0);
            state <= RUN;
          end
        end
        RUN: begin
          // last wins over abort; either way cnt freezes at its current value
          if (last || abort) begin
            run   <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt  <= cnt_inc[W-1:0];
            last <= (cnt_inc == lm1_run);
          end
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_et_len_ctrl.sv
// tb/tb_et_len_ctrl.sv - directed vector bench for et_len_ctrl
module tb_et_len_ctrl;

  localparam int W  = 6;
  localparam int C  = 2;
  localparam int PW = $clog2(W+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            et_en;
  logic            in_valid;
  logic            in_ready;
  logic [C*W-1:0]  bx;
  logic            abort;
  logic            run;
  logic [W-1:0]    cnt;
  logic            last;
  logic [PW-1:0]   prec;
  logic            done;

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic [C*W-1:0] bx;
    logic           et;
    int             abort_at;   // -1 none, -2 during CALC, else cnt value
    bit             hold;       // keep in_valid high through the stream
    int             prec;
    int             runs;
    int             fcnt;       // -1 means not checked
    int             dlat;
  } vec_t;

  vec_t vecs [9];

  et_len_ctrl #(.W(W), .C(C)) dut (
    .clk(clk), .rst(rst), .et_en(et_en), .in_valid(in_valid), .in_ready(in_ready),
    .Bx(bx), .abort(abort), .run(run), .cnt(cnt), .last(last), .prec(prec), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int runs, seq_err, done_t, fin_cnt, dones;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", idx), in_ready, 1);
    bx = v.bx; et_en = v.et; in_valid = 1'b1;
    runs = 0; seq_err = 0; done_t = -1; fin_cnt = -1; dones = 0;
    for (int t = 1; t <= 100 && done_t < 0; t++) begin
      @(negedge clk);
      if (!v.hold) in_valid = 1'b0;
      abort = 1'b0;
      if (run) begin
        if (cnt != W'(runs)) seq_err++;
        if (last != (runs == (1 << v.prec) - 1)) seq_err++;
        if (in_ready) seq_err++;
        runs++;
      end else if (last) seq_err++;
      if (done) begin
        done_t = t; fin_cnt = cnt; in_valid = 1'b0; dones++;
      end
      if (v.abort_at == -2 && t == 1) abort = 1'b1;
      if (run && v.abort_at >= 0 && int'(cnt) == v.abort_at) abort = 1'b1;
    end
    abort = 1'b0;
    chk($sformatf("v%0d done_latency", idx), done_t, v.dlat);
    chk($sformatf("v%0d prec", idx), prec, v.prec);
    chk($sformatf("v%0d run_cycles", idx), runs, v.runs);
    chk($sformatf("v%0d cnt_last_seq_errors", idx), seq_err, 0);
    if (v.fcnt >= 0) chk($sformatf("v%0d final_cnt", idx), fin_cnt, v.fcnt);
    @(negedge clk);
    if (done) dones++;
    chk($sformatf("v%0d done_pulses", idx), dones, 1);
    chk($sformatf("v%0d ready_after", idx), in_ready, 1);
    chk($sformatf("v%0d run_after", idx), run, 0);
    chk($sformatf("v%0d cnt_held", idx), cnt, (fin_cnt < 0) ? 0 : fin_cnt);
  endtask

  initial begin
    //        bx                         et  abort hold prec runs fcnt dlat
    vecs[0] = '{12'b000000_001100, 1'b1, -1, 1'b0, 4, 16, 15, 18};
    vecs[1] = '{12'b000000_000000, 1'b1, -1, 1'b0, 0,  1,  0,  3};
    vecs[2] = '{12'b110000_000011, 1'b1, -1, 1'b0, 6, 64, 63, 66};
    vecs[3] = '{12'b000000_001100, 1'b0, -1, 1'b0, 6, 64, 63, 66};
    vecs[4] = '{12'b000000_001100, 1'b1,  5, 1'b1, 4,  6,  5,  8};
    vecs[5] = '{12'b000000_001100, 1'b1, 15, 1'b0, 4, 16, 15, 18};
    vecs[6] = '{12'b000000_001100, 1'b1, -2, 1'b0, 4,  0, -1,  2};
    vecs[7] = '{12'b000010_100000, 1'b1, -1, 1'b0, 5, 32, 31, 34};
    vecs[8] = '{12'b001000_000000, 1'b1, -1, 1'b0, 3,  8,  7, 10};

    rst = 1'b1; et_en = 1'b0; in_valid = 1'b0; bx = '0; abort = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset run", run, 0);
    chk("reset prec", prec, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply(vecs[i], i);

    // asynchronous reset in the middle of a 64-cycle stream
    @(negedge clk);
    bx = 12'b110000_000011; et_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst run", run, 1);
    chk("pre_rst prec", prec, 6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst run", run, 0);
    chk("async_rst cnt", cnt, 0);
    chk("async_rst prec", prec, 0);
    chk("async_rst last", last, 0);
    chk("async_rst done", done, 0);
    chk("async_rst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", in_ready, 1);
    chk("post_rst run", run, 0);
    apply(vecs[8], 9);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
